seq_shift_add_multiplier: RTL and testbench



---
 rtl/seq_shift_add_multiplier_if.sv | 16 +
 rtl/seq_shift_add_multiplier.sv | 111 +++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result bundle for seq_shift_add_multiplier: start/busy/done handshake,
// operands, signed request and product.
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 signed_op;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   Product;

    modport master (output start, A, B, signed_op, input busy, done, Product);
    modport slave  (input start, A, B, signed_op, output busy, done, Product);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Shift-add multiplier: one multiplier bit per clock through a single WIDTH+1-bit adder.
// Define MULT_SIGNED_EN to add two's-complement operation selected by signed_op.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    seq_shift_add_multiplier_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [CW-1:0]        r_count;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;

`ifdef MULT_SIGNED_EN
    logic                 r_signed;
    logic [WIDTH:0]       w_ext_hi;
    logic [WIDTH:0]       w_ext_m;

    // Sign-extending both adder inputs makes w_sum[WIDTH] the arithmetic-shift fill bit.
    always_comb begin
        w_ext_hi = {r_signed & r_acc[2*WIDTH-1], r_acc[2*WIDTH-1:WIDTH]};
        w_ext_m  = {r_signed & r_mcand[WIDTH-1], r_mcand};
        w_sum    = w_ext_hi;
        if (r_acc[0]) begin
            if (r_signed && (r_count == LAST))
                w_sum = w_ext_hi - w_ext_m;
            else
                w_sum = w_ext_hi + w_ext_m;
        end
    end
`else
    logic w_unused_signed_op;
    assign w_unused_signed_op = bus.signed_op;

    always_comb begin
        w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        if (r_acc[0])
            w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    end
`endif

    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
`ifdef MULT_SIGNED_EN
            r_signed  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_mcand  <= bus.A;
                        r_acc    <= {{WIDTH{1'b0}}, bus.B};
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
`ifdef MULT_SIGNED_EN
                        r_signed <= bus.signed_op;
`endif
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST) begin
                        r_product <= w_acc_next;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.Product = r_product;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier at WIDTH=4 and WIDTH=8; products
// are checked when done pulses. Signed cases follow MULT_SIGNED_EN.
module tb_seq_shift_add_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    seq_shift_add_multiplier_if #(.WIDTH(4)) b4 ();
    seq_shift_add_multiplier_if #(.WIDTH(8)) b8 ();

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input bit s);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = {4'b0, a};
        eb = {4'b0, b};
`ifdef MULT_SIGNED_EN
        if (s) begin
            ea = {{4{a[3]}}, a};
            eb = {{4{b[3]}}, b};
        end
`endif
        return ea * eb;
    endfunction

    always @(negedge clk) begin
        if (!rst && b4.done) begin
            if (q4.size() == 0) check_eq("done4_spurious", 1, 0);
            else check_eq("prod4", b4.Product, q4.pop_front());
        end
        if (!rst && b8.done) begin
            if (q8.size() == 0) check_eq("done8_spurious", 1, 0);
            else check_eq("prod8", b8.Product, q8.pop_front());
        end
    end

    // Called at a negedge; drives a request, pushes its expected product, returns
    // at the negedge following the accepting edge.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit s, input bit drop);
        b4.start = 1'b1; b4.A = a; b4.B = b; b4.signed_op = s;
        q4.push_back(model4(a, b, s));
        @(posedge clk);
        @(negedge clk);
        if (drop) b4.start = 1'b0;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        b8.start = 1'b1; b8.A = a; b8.B = b; b8.signed_op = 1'b0;
        q8.push_back({8'b0, a} * {8'b0, b});
        @(posedge clk);
        @(negedge clk);
        b8.start = 1'b0;
    endtask

    // Counts busy negedges until done; ends at the negedge showing done.
    task automatic wait_done(input int w, output int nb);
        nb = 0;
        while (((w == 4) ? b4.busy : b8.busy) && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        check_eq($sformatf("done%0d_seen", w), (w == 4) ? b4.done : b8.done, 1);
    endtask

    initial begin
        int nb;
        b4.start = 1'b0; b4.A = '0; b4.B = '0; b4.signed_op = 1'b0;
        b8.start = 1'b0; b8.A = '0; b8.B = '0; b8.signed_op = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", b4.busy, 0);
        check_eq("rst_done", b4.done, 0);
        check_eq("rst_prod", b4.Product, 0);
        rst = 1'b0;
        @(negedge clk);

        // 15*15 with latency and hold checks
        op4(4'd15, 4'd15, 1'b0, 1'b1);
        wait_done(4, nb);
        check_eq("lat4_15x15", nb, 4);
        check_eq("busy_in_done", b4.busy, 0);
        repeat (3) @(negedge clk);
        check_eq("hold_prod", b4.Product, 8'hE1);
        check_eq("done_one_cycle", b4.done, 0);

        // back-to-back with start held
        op4(4'd13, 4'd11, 1'b0, 1'b0);
        b4.A = 4'd0; b4.B = 4'd9;
        wait_done(4, nb);
        check_eq("lat4_13x11", nb, 4);
        q4.push_back(model4(4'd0, 4'd9, 1'b0));
        @(posedge clk);
        @(negedge clk);
        b4.start = 1'b0;
        check_eq("b2b_accept", b4.busy, 1);
        wait_done(4, nb);
        check_eq("lat4_b2b", nb + 1, 5);
        @(negedge clk);

        // request during RUN is ignored
        op4(4'd3, 4'd5, 1'b0, 1'b0);
        b4.A = 4'd7; b4.B = 4'd7;
        @(negedge clk);
        @(negedge clk);
        b4.start = 1'b0;
        wait_done(4, nb);
        check_eq("lat4_ignore", nb + 2, 4);
        @(negedge clk);
        check_eq("idle_busy", b4.busy, 0);
        check_eq("idle_done", b4.done, 0);

        // asynchronous abort
        b4.start = 1'b1; b4.A = 4'd9; b4.B = 4'd9;
        @(posedge clk);
        @(negedge clk);
        b4.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_busy", b4.busy, 0);
        check_eq("abort_done", b4.done, 0);
        check_eq("abort_prod", b4.Product, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("abort_no_done", b4.done, 0);
        op4(4'd2, 4'd3, 1'b0, 1'b1);
        wait_done(4, nb);
        @(negedge clk);

        // signed cases; without the macro these run unsigned
        op4(4'b1000, 4'b1000, 1'b1, 1'b1);
        wait_done(4, nb);
        @(negedge clk);
        op4(4'b1101, 4'd5, 1'b1, 1'b1);
        wait_done(4, nb);
        check_eq("lat4_signed", nb, 4);
        @(negedge clk);
        op4(4'b1101, 4'd5, 1'b0, 1'b1);
        wait_done(4, nb);
        @(negedge clk);

        // WIDTH=8
        op8(8'd255, 8'd255);
        wait_done(8, nb);
        check_eq("lat8", nb, 8);
        @(negedge clk);
        op8(8'd128, 8'd2);
        wait_done(8, nb);
        @(negedge clk);
        op8(8'd0, 8'd0);
        wait_done(8, nb);
        check_eq("lat8_zero", nb, 8);
        repeat (2) @(negedge clk);

        check_eq("q4_drained", q4.size(), 0);
        check_eq("q8_drained", q8.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
